// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM stream feeder: default dimensions,
// feeder FSM state encoding and the packed result record used by
// engine-side logic.
package mvm_pkg;

  localparam int MVM_N  = 3;
  localparam int MVM_IW = 8;
  localparam int MVM_OW = 16;

  localparam logic [15:0] MVM_LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } feed_state_t;

  typedef struct packed {
    logic                     ovf;
    logic signed [MVM_OW-1:0] y;
  } mvm_result_t;

endpackage

// File: rtl/mvm_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to throttle the feeder
// handshakes in stress builds. Steps once per cycle while en is high.
module mvm_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  // Shift register with synchronous active-low reload of the seed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/mvm_stream_feeder.sv
// Initiator end of the MVM stream protocol. Holds one job (NxN matrix
// row-major followed by the N-vector), streams it word by word to an
// engine over valid/ready, then captures the N results and their overflow
// flags into a readable result buffer.
// Optional build macro MVM_FEED_THROTTLE_EN: an LFSR randomly gates the
// rise of m_valid and the s_ready level to stress the engine handshakes.
module mvm_stream_feeder
  import mvm_pkg::*;
#(
  parameter int          N         = MVM_N,
  parameter int          IW        = MVM_IW,
  parameter int          OW        = MVM_OW,
  parameter logic [15:0] LFSR_SEED = MVM_LFSR_SEED,
  localparam int         J         = N * N + N,
  localparam int         AW        = $clog2(J),
  localparam int         RW        = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic signed [IW-1:0] ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [IW-1:0] m_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [OW-1:0] s_data,
  input  logic                 s_overflow,
  input  logic [RW-1:0]        rd_addr,
  output logic signed [OW-1:0] rd_data,
  output logic                 rd_ovf
);

  localparam logic [AW-1:0] SND_LAST = AW'(J - 1);
  localparam logic [RW-1:0] RCV_LAST = RW'(N - 1);

  feed_state_t          state;
  logic [AW-1:0]        snd_cnt;
  logic [RW-1:0]        rcv_cnt;
  logic                 m_valid_q;
  logic                 s_ready_q;
  logic                 snd_go;
  logic                 m_xfer;
  logic                 s_xfer;

  logic signed [IW-1:0] job     [J];
  logic signed [OW-1:0] res_y   [N];
  logic                 res_ovf [N];

`ifdef MVM_FEED_THROTTLE_EN
  logic [15:0] lfsr;

  mvm_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .q     (lfsr)
  );

  // m_valid may only be raised when lfsr[0] is set; s_ready follows lfsr[1]
  // while receiving.
  assign snd_go  = lfsr[0];
  assign s_ready = s_ready_q & lfsr[1];
`else
  assign snd_go  = 1'b1;
  assign s_ready = s_ready_q;
`endif

  assign m_xfer  = m_valid_q & m_ready;
  assign s_xfer  = s_valid & s_ready;

  // m_data is addressed by the registered send counter, so it cannot move
  // while a word is stalled.
  assign m_valid = m_valid_q;
  assign m_data  = job[snd_cnt];
  assign rd_data = res_y[rd_addr];
  assign rd_ovf  = res_ovf[rd_addr];

  // Job control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      snd_cnt   <= '0;
      rcv_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SEND;
            busy      <= 1'b1;
            snd_cnt   <= '0;
            rcv_cnt   <= '0;
            m_valid_q <= snd_go;
          end
        end
        ST_SEND: begin
          if (m_xfer) begin
            if (snd_cnt == SND_LAST) begin
              state     <= ST_RECV;
              m_valid_q <= 1'b0;
              s_ready_q <= 1'b1;
            end else begin
              snd_cnt   <= snd_cnt + AW'(1);
              m_valid_q <= snd_go;
            end
          end else if (!m_valid_q) begin
            m_valid_q <= snd_go;
          end
        end
        ST_RECV: begin
          if (s_xfer) begin
            if (rcv_cnt == RCV_LAST) begin
              state     <= ST_DONE;
              s_ready_q <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              rcv_cnt <= rcv_cnt + RW'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Result buffer: cleared by reset, overflow flags cleared at job start,
  // one entry captured per accepted result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        res_y[i]   <= '0;
        res_ovf[i] <= 1'b0;
      end
    end else if (state == ST_IDLE && start) begin
      for (int i = 0; i < N; i++) begin
        res_ovf[i] <= 1'b0;
      end
    end else if (state == ST_RECV && s_xfer) begin
      res_y[rcv_cnt]   <= s_data;
      res_ovf[rcv_cnt] <= s_overflow;
    end
  end

  // Job buffer write port; locked while a job is running and during reset.
  always_ff @(posedge clk) begin
    if (reset && ld_en && !busy && (int'(ld_addr) < J)) begin
      job[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_mvm_stream_feeder.sv
// Scoreboard bench for mvm_stream_feeder. The main process loads jobs and
// pushes hand-computed expectations; a small engine responder computes the
// matrix-vector product from the words it receives; a monitor pops and
// compares words and results as the DUT presents them.
`timescale 1ns/1ps
module tb_mvm_stream_feeder;

  localparam int N  = 3;
  localparam int IW = 8;
  localparam int OW = 16;
  localparam int J  = N * N + N;
  localparam int AW = $clog2(J);
  localparam int RW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ld_en;
  logic [AW-1:0]        ld_addr;
  logic signed [IW-1:0] ld_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [IW-1:0] m_data;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [OW-1:0] s_data;
  logic                 s_overflow;
  logic [RW-1:0]        rd_addr;
  logic signed [OW-1:0] rd_data;
  logic                 rd_ovf;

  always #5 clk = ~clk;

  mvm_stream_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_overflow (s_overflow),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ovf     (rd_ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic signed [IW-1:0] exp_words [$];
  int                   exp_res_y [$];
  bit                   exp_res_o [$];
  logic signed [IW-1:0] rx_words  [$];

  int res_sent   = 0;
  int done_cnt   = 0;
  int stall_at   = -1;
  int stall_left = 0;
  int stall_seen = 0;
  bit eng_abort  = 1'b0;
  bit chk_zero   = 1'b0;

  int job1 [J] = '{1, -8, 3, 9, -5, 11, -7, 8, -9, 1, -22, 3};
  int y1   [N] = '{186, 152, -210};
  bit o1   [N] = '{0, 0, 0};
  int job2 [J] = '{10, 11, 12, 127, 127, 127, 1, 2, 3, 127, 127, 127};
  int y2   [N] = '{4191, -17149, 762};
  bit o2   [N] = '{0, 1, 0};

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, pops expectations on every word
  // transfer and on every done pulse.
  initial begin : monitor
    logic                 prev_hold;
    logic signed [IW-1:0] prev_data;
    logic                 prev_done;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_done = 1'b0;
    rd_addr   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (prev_hold) begin
          check("mvalid_hold", m_valid, 1);
          check("mdata_hold", m_data, prev_data);
        end
        if (prev_done) check("done_pulse", done, 0);
        if (m_valid && m_ready) begin
          rx_words.push_back(m_data);
          if (exp_words.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_word: got word %0d, expected none", m_data);
          end else begin
            check("word", m_data, exp_words.pop_front());
          end
        end
        if (m_valid && !m_ready) stall_seen++;
        if (s_valid && s_ready) res_sent++;
        if (done) begin
          done_cnt++;
          check("words_left", exp_words.size(), 0);
          for (int i = 0; i < N; i++) begin
            rd_addr = RW'(i);
            #1;
            if (exp_res_y.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL extra_result: got %0d, expected none", rd_data);
            end else begin
              check("rd_data", rd_data, exp_res_y.pop_front());
              check("rd_ovf", rd_ovf, exp_res_o.pop_front());
            end
          end
          rd_addr = '0;
        end
        if (chk_zero) begin
          for (int i = 0; i < N; i++) begin
            rd_addr = RW'(i);
            #1;
            check("rst_rd_data", rd_data, 0);
            check("rst_rd_ovf", rd_ovf, 0);
          end
          rd_addr  = '0;
          chk_zero = 1'b0;
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        prev_done = done;
      end else begin
        prev_hold = 1'b0;
        prev_done = 1'b0;
      end
    end
  end

  // Engine responder: accepts words (with an optional stall window), then
  // returns the wrapped products and overflow flags one by one.
  initial begin : engine
    int     eng_y [N];
    bit     eng_o [N];
    bit     have_res;
    longint acc;
    have_res   = 1'b0;
    m_ready    = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    s_overflow = 1'b0;
    forever begin
      tick();
      if (eng_abort) begin
        rx_words.delete();
        res_sent  = 0;
        have_res  = 1'b0;
        s_valid   = 1'b0;
        eng_abort = 1'b0;
      end
      m_ready = 1'b1;
      if (stall_left > 0 && rx_words.size() == stall_at) begin
        m_ready = 1'b0;
        stall_left--;
      end
      if (!have_res && rx_words.size() == J) begin
        for (int i = 0; i < N; i++) begin
          acc = 0;
          for (int k = 0; k < N; k++)
            acc += longint'(rx_words[i*N+k]) * longint'(rx_words[N*N+k]);
          eng_y[i] = int'(acc);
          eng_o[i] = (acc > 32767) || (acc < -32768);
        end
        have_res = 1'b1;
      end
      if (have_res && res_sent < N) begin
        s_valid    = 1'b1;
        s_data     = OW'(eng_y[res_sent]);
        s_overflow = eng_o[res_sent];
      end else begin
        s_valid = 1'b0;
        if (have_res) begin
          have_res = 1'b0;
          rx_words.delete();
          res_sent = 0;
        end
      end
    end
  end

  task automatic load_job(input int w [J]);
    for (int i = 0; i < J; i++) begin
      ld_en   = 1'b1;
      ld_addr = AW'(i);
      ld_data = IW'(w[i]);
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic run_job(input int w [J], input int ey [N], input bit eo [N],
                         input bit inject);
    int base;
    for (int i = 0; i < J; i++) exp_words.push_back(IW'(w[i]));
    for (int i = 0; i < N; i++) begin
      exp_res_y.push_back(ey[i]);
      exp_res_o.push_back(eo[i]);
    end
    base  = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
`ifndef MVM_FEED_THROTTLE_EN
    check("mvalid_latency", m_valid, 1);
`endif
    for (int c = 0; c < 300 && done_cnt == base; c++) begin
      if (inject && (c == 2 || c == 12)) begin
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_addr = (c == 2) ? AW'(0) : AW'(J - 1);
        ld_data = (c == 2) ? IW'(99) : IW'(-99);
      end
      tick();
      start = 1'b0;
      ld_en = 1'b0;
    end
    repeat (2) tick();
    check("done_count", done_cnt, base + 1);
    check("busy_idle", busy, 0);
    if (done_cnt == base) begin
      exp_words.delete();
      exp_res_y.delete();
      exp_res_o.delete();
    end
  endtask

  // Main sequence.
  initial begin : stim
    reset   = 1'b0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    start   = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_sready", s_ready, 0);
    reset    = 1'b1;
    chk_zero = 1'b1;
    repeat (2) tick();

    // Test 1: mixed-sign job, no overflow
    load_job(job1);
    run_job(job1, y1, o1, 1'b0);

    // Test 2: saturating row wraps and flags overflow
    load_job(job2);
    run_job(job2, y2, o2, 1'b0);

    // Test 3: five-cycle m_ready stall after the fifth word
    stall_seen = 0;
    stall_at   = 5;
    stall_left = 5;
    run_job(job2, y2, o2, 1'b0);
`ifndef MVM_FEED_THROTTLE_EN
    check("stall_cycles", stall_seen, 5);
`endif
    stall_at = -1;

    // Test 4: start/ld_en during SEND and RECV are ignored; rerun proves
    // the buffer was not touched
    run_job(job2, y2, o2, 1'b1);
    run_job(job2, y2, o2, 1'b0);

    // Test 5: reset in RECV after one result, then a clean job
    for (int i = 0; i < J; i++) exp_words.push_back(IW'(job2[i]));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 300 && res_sent < 1; c++) tick();
    check("res_before_abort", res_sent, 1);
    reset     = 1'b0;
    eng_abort = 1'b1;
    tick();
    check("abort_mvalid", m_valid, 0);
    check("abort_sready", s_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset    = 1'b1;
    chk_zero = 1'b1;
    repeat (2) tick();
    check("abort_words_left", exp_words.size(), 0);
    exp_words.delete();
    load_job(job1);
    run_job(job1, y1, o1, 1'b0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
